sha2_round_unit: RTL and testbench

- Parametrised SHA-2 compression-round engine; successor of the fixed SHA-256 round unit.
- Supports 32-bit (SHA-224/256) and 64-bit (SHA-384/512) words and a configurable round count.
- Adds a ready/valid word/constant stream, a start delay, optional final feed-forward addition and abort-by-restart.
- Sits between the message-schedule unit (W source), the constant ROM (K source) and the hash-state registers in the crypto accelerator datapath.

---
 rtl/sha2_pkg.sv | 28 ++
 rtl/sha2_round_comb.sv | 38 +++
 rtl/sha2_round_unit.sv | 136 +++++++++++++
 tb/tb_sha2_round_unit.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha2_pkg.sv
// Shared types and constants for the SHA-2 compression-round engine.
package sha2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_ROUND = 2'd2,
    ST_FFWD  = 2'd3
  } sha2_st_e;

  // [width: 0=32b, 1=64b][sigma: 0=S0, 1=S1][term]
  localparam int unsigned ROT_TBL [2][2][3] = '{
    '{'{2, 13, 22},  '{6, 11, 25}},
    '{'{28, 34, 39}, '{14, 18, 41}}
  };

  function automatic bit data_w_ok(input int unsigned dw);
    return (dw == 32) || (dw == 64);
  endfunction

  function automatic int unsigned rot_amt(input int unsigned dw, input int unsigned sig,
                                          input int unsigned idx);
    int unsigned wsel;
    wsel = (dw == 64) ? 1 : 0;
    return ROT_TBL[wsel][sig][idx];
  endfunction

endpackage

// File: rtl/sha2_round_comb.sv
// One SHA-2 compression round, purely combinational. Word 7 is a, word 0 is h.
module sha2_round_comb
  import sha2_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [7:0][DATA_W-1:0] st_i,
  input  logic [DATA_W-1:0]      w_i,
  input  logic [DATA_W-1:0]      k_i,
  output logic [7:0][DATA_W-1:0] st_o
);

  localparam int unsigned S0A = rot_amt(DATA_W, 0, 0);
  localparam int unsigned S0B = rot_amt(DATA_W, 0, 1);
  localparam int unsigned S0C = rot_amt(DATA_W, 0, 2);
  localparam int unsigned S1A = rot_amt(DATA_W, 1, 0);
  localparam int unsigned S1B = rot_amt(DATA_W, 1, 1);
  localparam int unsigned S1C = rot_amt(DATA_W, 1, 2);

  function automatic logic [DATA_W-1:0] rotr(input logic [DATA_W-1:0] x, input int unsigned n);
    return (x >> n) | (x << (DATA_W - n));
  endfunction

  logic [DATA_W-1:0] a, b, c, d, e, f, g, h;
  logic [DATA_W-1:0] sig0, sig1, ch, maj, t1, t2;

  always_comb begin
    {a, b, c, d, e, f, g, h} = st_i;
    sig0 = rotr(a, S0A) ^ rotr(a, S0B) ^ rotr(a, S0C);
    sig1 = rotr(e, S1A) ^ rotr(e, S1B) ^ rotr(e, S1C);
    ch   = (e & f) ^ (~e & g);
    maj  = (a & b) ^ (a & c) ^ (b & c);
    t1   = h + sig1 + ch + k_i + w_i;
    t2   = sig0 + maj;
    st_o = {t1 + t2, a, b, c, d + t1, e, f, g};
  end

endmodule

// File: rtl/sha2_round_unit.sv
// SHA-2 round engine: consumes one W/K pair per round over a ready/valid stream,
// with start delay, optional feed-forward of the initial state and restart on run.
module sha2_round_unit
  import sha2_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ROUNDS  = 64,
  parameter int unsigned DELAY_W = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        run,
  input  logic [DELAY_W-1:0]          delay,
  input  logic                        feedforward,
  input  logic [8*DATA_W-1:0]         state_in,
  input  logic [DATA_W-1:0]           w_in,
  input  logic [DATA_W-1:0]           k_in,
  input  logic                        wk_valid,
  output logic                        wk_ready,
  output logic [8*DATA_W-1:0]         state_out,
  output logic                        out_valid,
  output logic [$clog2(ROUNDS+1)-1:0] round_cnt,
  output logic                        busy,
  output logic                        done
);

  localparam int unsigned CNT_W = $clog2(ROUNDS + 1);
  localparam int unsigned NW    = 8;

  if (!data_w_ok(DATA_W)) begin : g_bad_data_w
    $error("sha2_round_unit: DATA_W must be 32 or 64");
  end
  if (ROUNDS < 1) begin : g_bad_rounds
    $error("sha2_round_unit: ROUNDS must be at least 1");
  end

  typedef logic [NW-1:0][DATA_W-1:0] st_t;

  sha2_st_e           fsm_q, fsm_d;
  st_t                work_q, work_d, init_q, init_d;
  st_t                st_in, rnd_nxt, ffwd_sum;
  logic [DELAY_W-1:0] dly_q, dly_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ff_q, ff_d, ov_q, ov_d, done_q, done_d;
  logic               fire, last;

  assign st_in = state_in;

  sha2_round_comb #(.DATA_W(DATA_W)) u_round (
    .st_i (work_q),
    .w_i  (w_in),
    .k_i  (k_in),
    .st_o (rnd_nxt)
  );

  for (genvar i = 0; i < NW; i++) begin : g_ffwd
    assign ffwd_sum[i] = work_q[i] + init_q[i];
  end

  assign wk_ready = (fsm_q == ST_ROUND);
  // A restart wins over a pending transfer in the same cycle.
  assign fire     = wk_valid & wk_ready & ~run;
  assign last     = (cnt_q == CNT_W'(ROUNDS - 1));

  always_comb begin
    fsm_d  = fsm_q;
    work_d = work_q;
    init_d = init_q;
    dly_d  = dly_q;
    cnt_d  = cnt_q;
    ff_d   = ff_q;
    ov_d   = 1'b0;
    done_d = 1'b0;
    if (run) begin
      work_d = st_in;
      init_d = st_in;
      dly_d  = delay;
      cnt_d  = '0;
      ff_d   = feedforward;
      fsm_d  = (delay == '0) ? ST_ROUND : ST_DELAY;
    end else begin
      case (fsm_q)
        ST_DELAY: begin
          dly_d = dly_q - 1'b1;
          if (dly_q == DELAY_W'(1)) fsm_d = ST_ROUND;
        end
        ST_ROUND: begin
          if (fire) begin
            work_d = rnd_nxt;
            cnt_d  = cnt_q + 1'b1;
            ov_d   = 1'b1;
            if (last) begin
              fsm_d  = ff_q ? ST_FFWD : ST_IDLE;
              done_d = ~ff_q;
            end
          end
        end
        ST_FFWD: begin
          work_d = ffwd_sum;
          done_d = 1'b1;
          fsm_d  = ST_IDLE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q  <= ST_IDLE;
      work_q <= '0;
      init_q <= '0;
      dly_q  <= '0;
      cnt_q  <= '0;
      ff_q   <= 1'b0;
      ov_q   <= 1'b0;
      done_q <= 1'b0;
    end else begin
      fsm_q  <= fsm_d;
      work_q <= work_d;
      init_q <= init_d;
      dly_q  <= dly_d;
      cnt_q  <= cnt_d;
      ff_q   <= ff_d;
      ov_q   <= ov_d;
      done_q <= done_d;
    end
  end

  assign state_out = work_q;
  assign out_valid = ov_q;
  assign round_cnt = cnt_q;
  assign done      = done_q;
  assign busy      = (fsm_q != ST_IDLE) | done_q;

endmodule

// File: tb/tb_sha2_round_unit.sv
// Scoreboard bench for sha2_round_unit: 32-bit/64-round and 64-bit/80-round instances.
module tb_sha2_round_unit;

  localparam logic [63:0] K512 [80] = '{
    64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
    64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
    64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
    64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
    64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
    64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
    64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
    64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
    64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
    64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
    64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
    64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
    64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
    64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
    64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
    64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
    64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
    64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
    64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
    64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
  };
  localparam logic [7:0][63:0] IV512 = {
    64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
    64'h510e527fade682d1, 64'h9b05688c2b3e6c1f, 64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179
  };
  localparam logic [7:0][63:0] D256 = {
    64'hba7816bf, 64'h8f01cfea, 64'h414140de, 64'h5dae2223,
    64'hb00361a3, 64'h96177a9c, 64'hb410ff61, 64'hf20015ad
  };

  typedef struct {
    bit               ov;
    bit               dn;
    logic [7:0][63:0] st;
    int               cnt;
  } exp_t;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  // Generic stimulus, routed to the selected instance (sel: 0 = 32-bit, 1 = 64-bit).
  logic             sel = 1'b0, g_run = 1'b0, g_ff = 1'b0, g_valid = 1'b0;
  logic [7:0]       g_dly = '0;
  logic [63:0]      g_w = '0, g_k = '0;
  logic [7:0][63:0] g_sti = '0;

  logic [7:0][31:0] st32_in, st32_out;
  logic [7:0][63:0] st64_out;
  logic [6:0]       cnt32, cnt64;
  logic rdy32, rdy64, ov32, ov64, bsy32, bsy64, dn32, dn64;

  logic [7:0][63:0] g_st;
  logic             g_ready, g_ov, g_busy, g_done;
  int               g_cnt;

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      st32_in[i] = g_sti[i][31:0];
      g_st[i]    = sel ? st64_out[i] : {32'h0, st32_out[i]};
    end
    g_ready = sel ? rdy64 : rdy32;
    g_ov    = sel ? ov64  : ov32;
    g_busy  = sel ? bsy64 : bsy32;
    g_done  = sel ? dn64  : dn32;
    g_cnt   = sel ? int'(cnt64) : int'(cnt32);
  end

  sha2_round_unit #(.DATA_W(32), .ROUNDS(64), .DELAY_W(8)) dut32 (
    .clk(clk), .rst_n(rst_n), .run(g_run & ~sel), .delay(g_dly), .feedforward(g_ff),
    .state_in(st32_in), .w_in(g_w[31:0]), .k_in(g_k[31:0]), .wk_valid(g_valid & ~sel),
    .wk_ready(rdy32), .state_out(st32_out), .out_valid(ov32), .round_cnt(cnt32),
    .busy(bsy32), .done(dn32)
  );

  sha2_round_unit #(.DATA_W(64), .ROUNDS(80), .DELAY_W(8)) dut64 (
    .clk(clk), .rst_n(rst_n), .run(g_run & sel), .delay(g_dly), .feedforward(g_ff),
    .state_in(g_sti), .w_in(g_w), .k_in(g_k), .wk_valid(g_valid & sel),
    .wk_ready(rdy64), .state_out(st64_out), .out_valid(ov64), .round_cnt(cnt64),
    .busy(bsy64), .done(dn64)
  );

  int               n_tests = 0, n_fail = 0;
  exp_t             expq[$];
  exp_t             mon_e;
  logic [7:0][63:0] hold_st = '0;
  int               hold_cnt = 0;
  bit               prev_ov = 1'b0, kat_en = 1'b0;
  logic [63:0]      wv [80];
  logic [63:0]      kv [80];

  task automatic check(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, req, $time);
    end
  endtask

  task automatic check_st(input logic [7:0][63:0] act, input logic [7:0][63:0] req, input string nm);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, req, $time);
    end
  endtask

  function automatic logic [63:0] wmask(input int dw);
    return (dw == 64) ? 64'hffff_ffff_ffff_ffff : 64'h0000_0000_ffff_ffff;
  endfunction

  function automatic logic [63:0] rotr(input logic [63:0] x, input int n, input int dw);
    logic [63:0] y;
    y = x & wmask(dw);
    return ((y >> n) | (y << (dw - n))) & wmask(dw);
  endfunction

  // "abc" padded block, expanded schedule, and the matching constant table.
  task automatic gen_abc(input int dw);
    logic [63:0] s0, s1;
    for (int i = 0; i < 16; i++) wv[i] = 64'h0;
    wv[0]  = (dw == 64) ? 64'h6162638000000000 : 64'h61626380;
    wv[15] = 64'h18;
    for (int i = 16; i < 80; i++) begin
      if (dw == 64) begin
        s0 = rotr(wv[i-15], 1, 64) ^ rotr(wv[i-15], 8, 64) ^ (wv[i-15] >> 7);
        s1 = rotr(wv[i-2], 19, 64) ^ rotr(wv[i-2], 61, 64) ^ (wv[i-2] >> 6);
      end else begin
        s0 = rotr(wv[i-15], 7, 32) ^ rotr(wv[i-15], 18, 32) ^ (wv[i-15] >> 3);
        s1 = rotr(wv[i-2], 17, 32) ^ rotr(wv[i-2], 19, 32) ^ (wv[i-2] >> 10);
      end
      wv[i] = (s1 + wv[i-7] + s0 + wv[i-16]) & wmask(dw);
    end
    for (int i = 0; i < 80; i++) kv[i] = (dw == 64) ? K512[i] : (K512[i] >> 32);
  endtask

  // Reference: textbook compression loop; pushes one expectation per visible output.
  task automatic model_push(input logic [7:0][63:0] init, input int dw, input int rounds,
                            input bit ff, output logic [7:0][63:0] fin);
    logic [63:0] m, a, b, c, d, e, f, g, h, t1, t2;
    int r0[3], r1[3];
    exp_t it;
    m = wmask(dw);
    if (dw == 64) begin r0 = '{28, 34, 39}; r1 = '{14, 18, 41}; end
    else begin r0 = '{2, 13, 22}; r1 = '{6, 11, 25}; end
    {a, b, c, d, e, f, g, h} = init;
    for (int r = 0; r < rounds; r++) begin
      t1 = (h + (rotr(e, r1[0], dw) ^ rotr(e, r1[1], dw) ^ rotr(e, r1[2], dw))
              + ((e & f) ^ (~e & g)) + kv[r] + wv[r]) & m;
      t2 = ((rotr(a, r0[0], dw) ^ rotr(a, r0[1], dw) ^ rotr(a, r0[2], dw))
              + ((a & b) ^ (a & c) ^ (b & c))) & m;
      h = g; g = f; f = e; e = (d + t1) & m;
      d = c; c = b; b = a; a = (t1 + t2) & m;
      it.ov = 1'b1; it.dn = (r == rounds - 1) && !ff;
      it.st = {a, b, c, d, e, f, g, h}; it.cnt = r + 1;
      expq.push_back(it);
    end
    fin = {a, b, c, d, e, f, g, h};
    if (ff) begin
      for (int i = 0; i < 8; i++) fin[i] = (fin[i] + init[i]) & m;
      it.ov = 1'b0; it.dn = 1'b1; it.st = fin; it.cnt = rounds;
      expq.push_back(it);
    end
  endtask

  // Monitor: pops on every out_valid/done; on stall cycles state and count must hold.
  always @(negedge clk) begin
    if (rst_n) begin
      if (g_ov || g_done) begin
        if (expq.size() == 0) begin
          check(1'b0, "sb_unexpected_output", {62'h0, g_ov, g_done}, 64'h0);
        end else begin
          mon_e = expq.pop_front();
          check({g_ov, g_done} == {mon_e.ov, mon_e.dn}, "sb_flags",
                {62'h0, g_ov, g_done}, {62'h0, mon_e.ov, mon_e.dn});
          check_st(g_st, mon_e.st, "sb_state");
          check(g_cnt == mon_e.cnt, "sb_round_cnt", 64'(g_cnt), 64'(mon_e.cnt));
          if (mon_e.dn && !mon_e.ov) check(prev_ov, "ffwd_after_last_round", 64'(prev_ov), 64'h1);
          if (kat_en && mon_e.ov && mon_e.cnt == 1)
            check(g_st[7] == 64'h5d6aebcd && g_st[3] == 64'hfa2a4622 && g_st[0] == 64'h1f83d9ab,
                  "kat_round1_a", g_st[7], 64'h5d6aebcd);
          hold_st  = mon_e.st;
          hold_cnt = mon_e.cnt;
        end
      end else if (g_busy) begin
        check_st(g_st, hold_st, "stall_state");
        check(g_cnt == hold_cnt, "stall_round_cnt", 64'(g_cnt), 64'(hold_cnt));
      end
      prev_ov = g_ov;
    end
  end

  task automatic check_zero(input string nm);
    check_st(g_st, '0, nm);
    check({g_ov, g_done, g_busy, g_ready} == 4'b0 && g_cnt == 0, nm,
          {57'h0, g_cnt[2:0], g_ov, g_done, g_busy, g_ready}, 64'h0);
  endtask

  // Called #1 after a posedge; returns #1 after the edge that sampled run.
  task automatic start_block(input bit s, input logic [7:0][63:0] init, input int dly,
                             input bit ff, input int dw, input int rounds,
                             output logic [7:0][63:0] fin);
    sel = s; g_sti = init; g_dly = 8'(dly); g_ff = ff; g_valid = 1'b0; g_run = 1'b1;
    @(posedge clk); #1;
    g_run = 1'b0;
    expq.delete();
    hold_st = init; hold_cnt = 0;
    model_push(init, dw, rounds, ff, fin);
    check(!g_ov && !g_done && g_cnt == 0, "restart_clears", 64'(g_cnt), 64'h0);
    check(g_busy == 1'b1, "busy_after_run", 64'(g_busy), 64'h1);
    check(g_ready == (dly == 0), "ready_first_cycle", 64'(g_ready), 64'(dly == 0));
  endtask

  task automatic feed(input int rounds, input int dly, input int duty, input int abort_at,
                      input bit chk_consec);
    int idx = 0, cyc = 1, first = -1, last_fire = -1, budget = 0;
    bit rdy;
    while (idx < rounds && budget < 3000) begin
      if (abort_at >= 0 && g_cnt == abort_at) return;
      g_w = wv[idx]; g_k = kv[idx];
      g_valid = ($urandom_range(0, 99) < duty);
      rdy = g_ready;
      if (rdy && first < 0) first = cyc;
      @(posedge clk);
      if (rdy && g_valid) begin idx++; last_fire = cyc; end
      #1; cyc++; budget++;
    end
    check(idx == rounds, "feed_all_rounds", 64'(idx), 64'(rounds));
    check(first == dly + 1, "ready_latency", 64'(first), 64'(dly + 1));
    if (chk_consec) check(last_fire - first + 1 == rounds, "consecutive_fires",
                          64'(last_fire - first + 1), 64'(rounds));
    g_valid = 1'b1;
    check(g_ready == 1'b0, "ready_drop_after_last", 64'(g_ready), 64'h0);
  endtask

  task automatic wait_done(input logic [7:0][63:0] req);
    int n = 0;
    while (!g_done && n < 10) begin @(posedge clk); #1; n++; end
    check(g_done == 1'b1, "done_seen", 64'(g_done), 64'h1);
    check_st(g_st, req, "digest");
    check(g_busy == 1'b1, "busy_with_done", 64'(g_busy), 64'h1);
    @(posedge clk); #1;
    g_valid = 1'b0;
    check(!g_busy && !g_done, "idle_after_done", {62'h0, g_busy, g_done}, 64'h0);
    check(expq.size() == 0, "scoreboard_drained", 64'(expq.size()), 64'h0);
  endtask

  task automatic rand_block(input bit s);
    logic [7:0][63:0] init, fin;
    int dw, rounds;
    dw = s ? 64 : 32; rounds = s ? 80 : 64;
    for (int i = 0; i < 8; i++) init[i] = {$urandom, $urandom} & wmask(dw);
    for (int i = 0; i < 80; i++) begin
      wv[i] = {$urandom, $urandom} & wmask(dw);
      kv[i] = {$urandom, $urandom} & wmask(dw);
    end
    start_block(s, init, $urandom_range(0, 3), 1'($urandom_range(0, 1)), dw, rounds, fin);
    feed(rounds, int'(g_dly), 60, -1, 1'b0);
    wait_done(fin);
  endtask

  logic [7:0][63:0] iv32, iv64, fin;

  initial begin
    for (int i = 0; i < 8; i++) begin
      iv64[i] = IV512[i];
      iv32[i] = IV512[i] >> 32;
    end
    repeat (3) @(posedge clk);
    #1 check_zero("reset_state_32");
    sel = 1'b1;
    #1 check_zero("reset_state_64");
    sel = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    gen_abc(32); kat_en = 1'b1;
    start_block(0, iv32, 0, 0, 32, 64, fin); feed(64, 0, 100, -1, 1'b1); wait_done(fin);
    kat_en = 1'b0;

    start_block(0, iv32, 0, 1, 32, 64, fin); feed(64, 0, 100, -1, 1'b1); wait_done(D256);

    gen_abc(64);
    start_block(1, iv64, 0, 1, 64, 80, fin); feed(80, 0, 100, -1, 1'b1); wait_done(fin);
    check(g_st[7] == 64'hddaf35a193617aba, "sha512_abc_a", g_st[7], 64'hddaf35a193617aba);

    gen_abc(32);
    start_block(0, iv32, 5, 1, 32, 64, fin); feed(64, 5, 100, -1, 1'b1); wait_done(D256);
    start_block(0, iv32, 0, 1, 32, 64, fin); feed(64, 0, 50, -1, 1'b0); wait_done(D256);

    for (int t = 0; t < 4; t++) rand_block(1'($urandom_range(0, 1)));

    gen_abc(32);
    start_block(0, iv32, 0, 1, 32, 64, fin); feed(64, 0, 70, 30, 1'b0);
    start_block(0, iv32, 0, 1, 32, 64, fin); feed(64, 0, 100, -1, 1'b1); wait_done(D256);

    start_block(0, iv32, 2, 1, 32, 64, fin); feed(64, 2, 80, 10, 1'b0);
    g_valid = 1'b0;
    #3 rst_n = 1'b0;
    #1 check_zero("async_reset_midblock");
    expq.delete(); hold_st = '0; hold_cnt = 0;
    @(posedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1;
    check_zero("after_reset_release");

    rand_block(1'b1);
    rand_block(1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
